fp_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point add/subtract unit, the successor to the combinational half-precision adder. It handles any exponent and mantissa width, selects add or subtract per operation, and rounds to nearest-even. It also handles zero, infinity and NaN and reports exception flags. It sits between the register-file read and the writeback stage of the multicycle datapath and uses a valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 47 ++++
 rtl/fp_lzc.sv | 34 +++
 rtl/fp_addsub_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fp_pkg                                                     |
// | Description : Shared definitions for the pipelined FP add/sub unit:      |
// |               default format widths and derived constants, flag bit     |
// |               indices, operand class encoding and a classify helper.    |
// |               The W/BIAS/EXP_MAX/QNAN constants describe the default    |
// |               (half-precision) format; the adder re-derives the same    |
// |               quantities from its own EXP_W/MAN_W parameters.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fp_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  localparam int W       = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int BIAS    = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W_DEF) - 1;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MAN_W_DEF-1){1'b0}}};

  // Bit positions within flags = {invalid, overflow, underflow, inexact}
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Subnormals (exponent 0, fraction non-zero) classify as zero: flushed.
  function automatic fp_class_e f_classify(input logic exp_ones,
                                           input logic exp_zero,
                                           input logic frac_zero);
    if (exp_zero)       return CLS_ZERO;
    else if (!exp_ones) return CLS_NORM;
    else if (frac_zero) return CLS_INF;
    else                return CLS_NAN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_lzc                                                     |
// | Description : Leading-zero counter. o_count is the number of zero bits  |
// |               above the most significant one (WIDTH for all-zero).     |
// | Ports       : i_data  [WIDTH-1:0]          value to scan                |
// |               o_count [clog2(WIDTH+1)-1:0] leading-zero count           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fp_lzc #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0]           i_data,
  output logic [$clog2(WIDTH+1)-1:0] o_count
);

  logic [$clog2(WIDTH+1)-1:0] w_cnt;
  logic                       w_found;

  always_comb begin
    w_cnt   = '0;
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (i_data[i]) w_found = 1'b1;
        else           w_cnt   = w_cnt + 1'b1;
      end
    end
  end

  assign o_count = w_cnt;

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_addsub_pipe                                             |
// | Description : Three-stage pipelined floating-point add/subtract with    |
// |               round-to-nearest-even, special-value handling and flags. |
// |               Stage 1 unpacks/swaps/aligns, stage 2 adds, stage 3      |
// |               normalises, rounds and packs into the output register.   |
// | Ports       : clk, reset (async, active-high)                            |
// |               in_valid/in_ready, a, b, op_sub   operand side             |
// |               out_valid/out_ready, result, flags result side            |
// |               flags = {invalid, overflow, underflow, inexact}          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int c_W       = 1 + EXP_W + MAN_W;
  localparam int c_EXP_MAX = (1 << EXP_W) - 1;
  localparam int c_MW      = MAN_W + 4;            // hidden + frac + G/R/S
  localparam int c_SW      = MAN_W + 5;            // plus carry-out
  localparam int c_LZW     = $clog2(c_SW + 1);
  localparam int c_XW      = ((EXP_W > c_LZW) ? EXP_W : c_LZW) + 2;
  localparam logic [c_W-1:0] c_QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------- handshake
  logic r1_valid, r2_valid, r_out_valid;
  logic w_s3_adv, w_s2_acc;

  assign w_s3_adv = out_ready || !r_out_valid;
  assign w_s2_acc = !r2_valid || w_s3_adv;
  assign in_ready = !r1_valid || w_s2_acc;

  // ------------------------------------------------------- stage 1 (comb)
  logic [EXP_W-1:0] w_ea, w_eb, w_l_exp, w_s_exp, w_diff;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_sa, w_sb, w_a_big, w_l_sign, w_s_sign, w_sticky;
  fp_class_e        w_ca, w_cb;
  logic [c_W-2:0]   w_mag_a, w_mag_b, w_mag_l, w_mag_s;
  logic [c_MW-1:0]  w_ml, w_ms, w_shr, w_ms_al;
  logic             w_spec;
  logic [c_W-1:0]   w_spec_res;
  logic [3:0]       w_spec_flg;

  assign w_ea = a[c_W-2 -: EXP_W];
  assign w_eb = b[c_W-2 -: EXP_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_fb = b[MAN_W-1:0];
  assign w_sa = a[c_W-1];
  assign w_sb = b[c_W-1] ^ op_sub;                 // effective sign of b
  assign w_ca = f_classify(&w_ea, ~|w_ea, ~|w_fa);
  assign w_cb = f_classify(&w_eb, ~|w_eb, ~|w_fb);

  // Flushed operands compare (and align) as true zeros.
  assign w_mag_a  = (w_ca == CLS_ZERO) ? '0 : a[c_W-2:0];
  assign w_mag_b  = (w_cb == CLS_ZERO) ? '0 : b[c_W-2:0];
  assign w_a_big  = (w_mag_a >= w_mag_b);
  assign w_mag_l  = w_a_big ? w_mag_a : w_mag_b;
  assign w_mag_s  = w_a_big ? w_mag_b : w_mag_a;
  assign w_l_sign = w_a_big ? w_sa : w_sb;
  assign w_s_sign = w_a_big ? w_sb : w_sa;
  assign w_l_exp  = w_mag_l[c_W-2 -: EXP_W];
  assign w_s_exp  = w_mag_s[c_W-2 -: EXP_W];

  // Hidden bit is present exactly when the exponent is non-zero.
  assign w_ml   = {|w_l_exp, w_mag_l[MAN_W-1:0], 3'b000};
  assign w_ms   = {|w_s_exp, w_mag_s[MAN_W-1:0], 3'b000};
  assign w_diff = w_l_exp - w_s_exp;
  // A shift of c_MW or more already yields zero, so the shift saturates
  // naturally; sticky catches any bit that did not survive the round trip.
  assign w_shr    = w_ms >> w_diff;
  assign w_sticky = ((w_shr << w_diff) != w_ms);
  assign w_ms_al  = w_shr | {{(c_MW-1){1'b0}}, w_sticky};

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (w_ca == CLS_NAN || w_cb == CLS_NAN) begin
      w_spec_res = c_QNAN;
    end else if (w_ca == CLS_INF && w_cb == CLS_INF && w_sa != w_sb) begin
      w_spec_res              = c_QNAN;
      w_spec_flg[FLG_INVALID] = 1'b1;
    end else if (w_ca == CLS_INF) begin
      w_spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_cb == CLS_INF) begin
      w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_ca == CLS_ZERO && w_cb == CLS_ZERO) begin
      w_spec_res = {w_sa & w_sb, {(c_W-1){1'b0}}};   // -0 only for (-0)+(-0)
    end else begin
      w_spec = 1'b0;
    end
  end

  // ------------------------------------------------------- stage 1 regs
  logic             r1_spec, r1_sign, r1_sub;
  logic [c_W-1:0]   r1_spec_res;
  logic [3:0]       r1_spec_flg;
  logic [EXP_W-1:0] r1_exp;
  logic [c_MW-1:0]  r1_ml, r1_ms;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_valid    <= 1'b0;
      r1_spec     <= 1'b0;
      r1_spec_res <= '0;
      r1_spec_flg <= '0;
      r1_sign     <= 1'b0;
      r1_sub      <= 1'b0;
      r1_exp      <= '0;
      r1_ml       <= '0;
      r1_ms       <= '0;
    end else if (in_ready) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_spec     <= w_spec;
        r1_spec_res <= w_spec_res;
        r1_spec_flg <= w_spec_flg;
        r1_sign     <= w_l_sign;
        r1_sub      <= (w_l_sign != w_s_sign);
        r1_exp      <= w_l_exp;
        r1_ml       <= w_ml;
        r1_ms       <= w_ms_al;
      end
    end
  end

  // ------------------------------------------------------- stage 2 regs
  logic             r2_spec, r2_sign;
  logic [c_W-1:0]   r2_spec_res;
  logic [3:0]       r2_spec_flg;
  logic [EXP_W-1:0] r2_exp;
  logic [c_SW-1:0]  r2_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_valid    <= 1'b0;
      r2_spec     <= 1'b0;
      r2_spec_res <= '0;
      r2_spec_flg <= '0;
      r2_sign     <= 1'b0;
      r2_exp      <= '0;
      r2_sum      <= '0;
    end else if (w_s2_acc) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_spec     <= r1_spec;
        r2_spec_res <= r1_spec_res;
        r2_spec_flg <= r1_spec_flg;
        r2_sign     <= r1_sign;
        r2_exp      <= r1_exp;
        // L >= S in magnitude, so the difference never goes negative.
        r2_sum      <= r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                              : ({1'b0, r1_ml} + {1'b0, r1_ms});
      end
    end
  end

  // ------------------------------------------------------- stage 3 (comb)
  logic [c_LZW-1:0] w_lz;
  logic [c_MW-1:0]  w_norm;
  logic [c_XW-1:0]  w_exp_n, w_exp_r;
  logic [MAN_W:0]   w_keep;
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_frac;
  logic             w_g, w_r, w_s, w_up, w_exp_le0;
  logic [c_W-1:0]   w_res;
  logic [3:0]       w_flg;

  fp_lzc #(.WIDTH(c_SW)) u_lzc (
    .i_data  (r2_sum),
    .o_count (w_lz)
  );

  always_comb begin
    w_norm  = '0;
    w_exp_n = '0;
    if (r2_sum[c_SW-1]) begin
      w_norm  = r2_sum[c_SW-1:1] | {{(c_MW-1){1'b0}}, r2_sum[0]};
      w_exp_n = {{(c_XW-EXP_W){1'b0}}, r2_exp} + c_XW'(1);
    end else begin
      // The carry bit is zero here, so the leading one sits lz-1 places
      // below the hidden-bit position.
      w_norm  = c_MW'(r2_sum << (w_lz - 1'b1));
      w_exp_n = {{(c_XW-EXP_W){1'b0}}, r2_exp} + c_XW'(1) - c_XW'(w_lz);
    end
  end

  assign w_keep    = w_norm[c_MW-1:3];
  assign w_g       = w_norm[2];
  assign w_r       = w_norm[1];
  assign w_s       = w_norm[0];
  assign w_up      = w_g & (w_r | w_s | w_keep[0]);
  assign w_rnd     = {1'b0, w_keep} + {{(MAN_W+1){1'b0}}, w_up};
  // Rounding carry-out means the mantissa became 10..0: renormalise.
  assign w_frac    = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_exp_r   = w_exp_n + c_XW'(w_rnd[MAN_W+1]);
  assign w_exp_le0 = w_exp_r[c_XW-1] || (w_exp_r == '0);

  always_comb begin
    w_res = '0;
    w_flg = '0;
    if (r2_spec) begin
      w_res = r2_spec_res;
      w_flg = r2_spec_flg;
    end else if (r2_sum == '0) begin
      w_res = '0;                                    // exact cancellation
    end else if (!w_exp_r[c_XW-1] && (w_exp_r >= c_XW'(c_EXP_MAX))) begin
      w_res                    = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flg[FLG_OVERFLOW]      = 1'b1;
      w_flg[FLG_INEXACT]       = 1'b1;
    end else if (w_exp_le0) begin
      w_res                    = {r2_sign, {(c_W-1){1'b0}}};
      w_flg[FLG_UNDERFLOW]     = 1'b1;
      w_flg[FLG_INEXACT]       = 1'b1;
    end else begin
      w_res                    = {r2_sign, w_exp_r[EXP_W-1:0], w_frac};
      w_flg[FLG_INEXACT]       = w_g | w_r | w_s;
    end
  end

  // ------------------------------------------------------- output regs
  logic [c_W-1:0] r_result;
  logic [3:0]     r_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_s3_adv) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_result <= w_res;
        r_flags  <= w_flg;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fp_addsub_pipe                                          |
// | Description : Self-checking bench for fp_addsub_pipe (half precision): |
// |               table of directed vectors with latency checks, a        |
// |               back-pressure stream and an in-flight reset sequence.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, got, exp);
    end
  endtask

  // Issue one operation with out_ready high and return the result and the
  // number of rising edges from the accepting edge to out_valid (inclusive).
  task automatic run_one(input vec_t v, output logic [15:0] r,
                         output logic [3:0] f, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    a = v.a; b = v.b; op_sub = v.sub; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = result;
    f = flags;
  endtask

  initial begin
    logic [15:0] r, held_r;
    logic [3:0]  f, held_f;
    int          lat, idx_in, idx_out, inflight, cyc;
    logic        stall_prev, take_in, take_out;

    vec[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000};
    vec[1]  = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000};
    vec[2]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001};
    vec[3]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001};
    vec[4]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000};
    vec[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000};
    vec[6]  = '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 4'b0000};
    vec[7]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101};
    vec[8]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000};
    vec[9]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0000};
    vec[10] = '{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 4'b0000};
    vec[11] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000};
    vec[12] = '{16'h3C00, 16'hFC00, 1'b0, 16'hFC00, 4'b0000};
    vec[13] = '{16'h0800, 16'h0600, 1'b1, 16'h0000, 4'b0011};
    vec[14] = '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0000};
    vec[15] = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 4'b0001};
    vec[16] = '{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 4'b0101};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0;
    out_ready = 1'b1;
    #12 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", {16'b0, result}, 32'd0);
    check("reset flags", {28'b0, flags}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      run_one(vec[i], r, f, lat);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d result", i), {16'b0, r}, {16'b0, vec[i].res});
      check($sformatf("vec%0d flags", i), {28'b0, f}, {28'b0, vec[i].flg});
    end

    // Back-pressure stream of 8 operations
    idx_in = 0; idx_out = 0; inflight = 0; cyc = 0; stall_prev = 1'b0;
    held_r = '0; held_f = '0;
    while (idx_out < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        check("stall out_valid held", {31'b0, out_valid}, 32'd1);
        check("stall result held", {16'b0, result}, {16'b0, held_r});
        check("stall flags held", {28'b0, flags}, {28'b0, held_f});
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx_in < 8);
      if (idx_in < 8) begin
        a = vec[idx_in].a; b = vec[idx_in].b; op_sub = vec[idx_in].sub;
      end
      #1;
      check("stream in_ready", {31'b0, in_ready},
            {31'b0, !(inflight == 3 && !out_ready)});
      take_in  = in_valid && in_ready;
      take_out = out_valid && out_ready;
      if (take_out) begin
        check($sformatf("stream result %0d", idx_out), {16'b0, result},
              {16'b0, vec[idx_out].res});
        check($sformatf("stream flags %0d", idx_out), {28'b0, flags},
              {28'b0, vec[idx_out].flg});
        idx_out++;
      end
      stall_prev = out_valid && !out_ready;
      held_r = result;
      held_f = flags;
      @(posedge clk);
      if (take_in) idx_in++;
      inflight = inflight + (take_in ? 1 : 0) - (take_out ? 1 : 0);
    end
    check("stream completed", idx_out, 8);

    // Drain, then reset with three operations in flight
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = vec[i].a; b = vec[i].b; op_sub = vec[i].sub; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", {31'b0, out_valid}, 32'd0);
    check("async reset result", {16'b0, result}, 32'd0);
    check("async reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no stale output", {31'b0, out_valid}, 32'd0);
    end
    run_one(vec[3], r, f, lat);
    check("post-reset latency", lat, 3);
    check("post-reset result", {16'b0, r}, {16'b0, vec[3].res});
    check("post-reset flags", {28'b0, f}, {28'b0, vec[3].flg});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
